scrambler_sync_param: RTL and testbench
=======================================

Name: scrambler_sync_param

Overview:
Parametrised self-synchronous scrambler and descrambler for 64b/66b-style links, using the polynomial x^TAP_B + x^TAP_A + 1 (default x^58+x^39+1).
- Processes DATA_W bits per accepted word.
- Valid/ready handshake with one registered output stage.
- Runtime seed reload.
- MODE selects scrambler or descrambler, so one block serves both the TX and RX paths between the PCS framing logic and the gearbox.

Parameters:
DATA_W, 64, bits per word, 1..256.
MODE, 0, 0 = scramble, 1 = descramble.
TAP_A, 39, short tap, 1 <= TAP_A < TAP_B.
TAP_B, 58, long tap; also the state length in bits.
SEED, {58{1'b1}}, TAP_B-bit state value loaded at reset and on seed_load.
REVERSE, 0, 0 = bit 0 is first on the wire; 1 = bit DATA_W-1 is first on the wire (applies to both in_data and out_data).

Ports:
CLK  in  1  rising-edge clock.
RST_N  in  1  asynchronous active-low reset.
in_valid  in  1  in_data is valid.
in_ready  out  1  block accepts a word this cycle.
in_data  in  DATA_W  input word.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream accepts out_data.
out_data  out  DATA_W  scrambled or descrambled word.
seed_load  in  1  synchronous pulse; reloads the state with SEED.
bypass  in  1  present only with SCR_BYPASS_EN (see Optional Feature).

Behaviour:
- Reset is asynchronous on RST_N low: out_valid=0, out_data=0, state=SEED. All logic runs on CLK with no other clock domain.
- Bit order:
  - Let d[k], k=0..DATA_W-1, be the wire order: d[k]=in_data[k] when REVERSE=0, and in_data[DATA_W-1-k] when REVERSE=1.
  - out_data is mapped back the same way.
- State is a TAP_B-bit history; h[j] is the bit j+1 positions before the current bit, j=0..TAP_B-1.
- MODE=0 (scramble): y[k] = d[k] ^ h(TAP_A) ^ h(TAP_B). The history is fed with y, i.e. the scrambled bits.
- MODE=1 (descramble): y[k] = d[k] ^ h(TAP_A) ^ h(TAP_B). The history is fed with d, i.e. the received bits.
- Bits within a word are evaluated in order k=0 upward. A tap that reaches back into the current word uses that word's bits.
- The state after a word holds the last TAP_B history bits. It must hold for any DATA_W, including DATA_W < TAP_B and DATA_W > TAP_B.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, i.e. one-entry pipeline with no bubble on streaming.
  - Latency is 1 cycle: a word accepted at edge N appears on out_data after edge N with out_valid=1.
  - out_valid clears on an output handshake with no new transfer.
  - While out_valid && !out_ready: out_data and the state are held stable, and in_ready=0.
- The state advances only on a transfer. Idle cycles and stalls never change the state.
- seed_load:
  - At the next edge, state := SEED.
  - If coincident with a transfer, that word is processed with the old state, and the state is still set to SEED (load wins).
  - seed_load does not affect out_valid or out_data.
- Descrambler self-sync: after TAP_B received bits following any state error, output equals the original data, independent of SEED.
- Reset mid-operation: any pending out_valid is dropped, the state returns to SEED, and in_ready=1 after reset release.

Optional Feature:
Macro SCR_BYPASS_EN.
- Defined: the bypass port exists. For a word accepted with bypass=1, y = d unchanged and the state is not updated; the handshake and latency are unchanged.
- Undefined: no bypass port, and all words are always processed.

Test Plan:
- Scramble zeros: MODE=0, DATA_W=64, reset, then one word in_data=0 -> out_data=64'h03FF_FF80_0000_0000 one cycle later.
- Loopback: scrambler feeding descrambler with 1000 random words and random in_valid/out_ready gaps -> descrambler output equals the stimulus exactly, in order, with no drops or duplicates.
- Self-sync: descrambler SEED=0 against a scrambler with SEED all-ones, DATA_W=64 -> first word may mismatch; word 2 onward matches.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, and the next output after release equals the expected scrambling of the next word.
- seed_load plus reset: pulse seed_load coincident with a transfer, then send zeros -> the second word equals the zero-input reset pattern. Assert RST_N=0 mid-stream -> out_valid=0 immediately (asynchronous).
- DATA_W=16, REVERSE=1, MODE=0 -> after 4 words, output matches the bit-serial reference model with MSB-first wire order.

Source files
------------

// File: rtl/scrambler_sync_param.sv
// Self-synchronous scrambler / descrambler, polynomial x^TAP_B + x^TAP_A + 1.
// MODE=0 scrambles (history fed with output bits), MODE=1 descrambles
// (history fed with received bits). One registered output stage with a
// valid/ready handshake, plus a synchronous seed reload.
// Optional feature: define SCR_BYPASS_EN to add the per-word bypass port.
module scrambler_sync_param #(
  parameter int unsigned     DATA_W  = 64,
  parameter int unsigned     MODE    = 0,
  parameter int unsigned     TAP_A   = 39,
  parameter int unsigned     TAP_B   = 58,
  parameter logic [TAP_B-1:0] SEED   = '1,
  parameter int unsigned     REVERSE = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef SCR_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              seed_load
);

  localparam bit FEED_OUT = (MODE == 32'd0);
  localparam bit REV      = (REVERSE != 32'd0);

  // state_q[j] is the history bit j+1 positions before the next wire bit
  logic [TAP_B-1:0]  state_q;
  logic [TAP_B-1:0]  hist;
  logic [TAP_B-1:0]  state_nxt;
  logic [DATA_W-1:0] d_w;
  logic [DATA_W-1:0] y_w;
  logic [DATA_W-1:0] word_c;
  logic              bit_y;
  logic              xfer;
  logic              bypass_c;

  // One-entry pipeline: accept whenever the output slot is free or draining
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

`ifdef SCR_BYPASS_EN
  assign bypass_c = bypass;
`else
  assign bypass_c = 1'b0;
`endif

  // Bit-serial evaluation of one word in wire order, unrolled across DATA_W
  always_comb begin
    d_w       = '0;
    y_w       = '0;
    word_c    = '0;
    bit_y     = 1'b0;
    hist      = state_q;
    state_nxt = state_q;
    for (int k = 0; k < int'(DATA_W); k++) begin
      d_w[k] = REV ? in_data[int'(DATA_W) - 1 - k] : in_data[k];
    end
    for (int k = 0; k < int'(DATA_W); k++) begin
      bit_y  = d_w[k] ^ hist[TAP_A-1] ^ hist[TAP_B-1];
      y_w[k] = bit_y;
      hist   = {hist[TAP_B-2:0], (FEED_OUT ? bit_y : d_w[k])};
    end
    state_nxt = hist;
    for (int k = 0; k < int'(DATA_W); k++) begin
      if (REV) word_c[int'(DATA_W) - 1 - k] = y_w[k];
      else     word_c[k] = y_w[k];
    end
    if (bypass_c) word_c = in_data;
  end

  // Output register: load on transfer, drop valid once drained
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= word_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // History register: advances only on a processed transfer; seed reload wins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEED;
    end else if (seed_load) begin
      state_q <= SEED;
    end else if (xfer && !bypass_c) begin
      state_q <= state_nxt;
    end
  end

endmodule

// File: tb/tb_scrambler_sync_param.sv
// Directed bench for scrambler_sync_param: zero pattern, streaming words,
// backpressure, seed reload, async reset, MSB-first 16-bit instance, and a
// scrambler->descrambler loopback with a wrong-seed descrambler alongside.
module tb_scrambler_sync_param;

  localparam int unsigned NL = 1000;
  localparam logic [63:0] ZERO_PAT = 64'h03FF_FF80_0000_0000;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // main 64-bit scrambler
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_seed_load;
  logic [63:0] s_in_data, s_out_data;
  // 16-bit MSB-first scrambler
  logic        rv_in_valid, rv_in_ready, rv_out_valid;
  logic [15:0] rv_in_data, rv_out_data;
  // loopback chain
  logic        ls_in_valid, ls_in_ready, ls_out_valid;
  logic [63:0] ls_in_data, ls_out_data;
  logic        ld_in_ready, ld_out_valid, ld_out_ready;
  logic [63:0] ld_out_data;
  logic        d0_in_ready, d0_out_valid;
  logic [63:0] d0_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  scrambler_sync_param #(.DATA_W(64), .MODE(0)) u_scr (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
`ifdef SCR_BYPASS_EN
    .bypass(1'b0),
`endif
    .seed_load(s_seed_load));

  scrambler_sync_param #(.DATA_W(16), .MODE(0), .REVERSE(1)) u_rv (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(rv_in_valid), .in_ready(rv_in_ready), .in_data(rv_in_data),
    .out_valid(rv_out_valid), .out_ready(1'b1), .out_data(rv_out_data),
`ifdef SCR_BYPASS_EN
    .bypass(1'b0),
`endif
    .seed_load(1'b0));

  scrambler_sync_param #(.DATA_W(64), .MODE(0)) u_ls (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(ls_in_valid), .in_ready(ls_in_ready), .in_data(ls_in_data),
    .out_valid(ls_out_valid), .out_ready(ld_in_ready), .out_data(ls_out_data),
`ifdef SCR_BYPASS_EN
    .bypass(1'b0),
`endif
    .seed_load(1'b0));

  scrambler_sync_param #(.DATA_W(64), .MODE(1)) u_ld (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(ls_out_valid), .in_ready(ld_in_ready), .in_data(ls_out_data),
    .out_valid(ld_out_valid), .out_ready(ld_out_ready), .out_data(ld_out_data),
`ifdef SCR_BYPASS_EN
    .bypass(1'b0),
`endif
    .seed_load(1'b0));

  scrambler_sync_param #(.DATA_W(64), .MODE(1), .SEED(58'd0)) u_d0 (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(ls_out_valid && ld_in_ready), .in_ready(d0_in_ready), .in_data(ls_out_data),
    .out_valid(d0_out_valid), .out_ready(1'b1), .out_data(d0_out_data),
`ifdef SCR_BYPASS_EN
    .bypass(1'b0),
`endif
    .seed_load(1'b0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Stream reference: seq holds the fed-back bit stream, oldest first,
  // with the 58 history bits in front of the current word.
  function automatic void ref_word(input int w, input bit mode, input logic [63:0] d,
                                   input logic [57:0] st, output logic [63:0] y,
                                   output logic [57:0] st_o);
    logic seq [0:121];
    logic yb;
    for (int j = 0; j < 58; j++) seq[57-j] = st[j];
    y = '0;
    for (int k = 0; k < w; k++) begin
      yb         = d[k] ^ seq[58+k-39] ^ seq[58+k-58];
      y[k]       = yb;
      seq[58+k]  = mode ? d[k] : yb;
    end
    for (int j = 0; j < 58; j++) st_o[j] = seq[58+w-1-j];
  endfunction

  logic [57:0] mst, rst_st;
  logic [63:0] exp_y, held, dw, yw;
  logic [15:0] exp16;
  logic [63:0] pat [4];
  logic [15:0] rpat [4];
  logic [63:0] sent_q [$];
  logic [63:0] want;
  int   got, got0, sent, cyc;
  bit   ls_acc;

  initial begin
    pat  = '{64'hA5A5_A5A5_A5A5_A5A5, 64'h0123_4567_89AB_CDEF,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};
    rpat = '{16'h0001, 16'hBEEF, 16'h8000, 16'h5A3C};
    RST_N = 1'b0;
    s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_seed_load = 0;
    rv_in_valid = 0; rv_in_data = '0;
    ls_in_valid = 0; ls_in_data = '0; ld_out_ready = 0;
    tick; tick;
    check("rst_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_out_data", s_out_data, 64'd0);
    check("rst_in_ready", 64'(s_in_ready), 64'd1);
    RST_N = 1'b1;
    mst = '1;

    // zero word after reset
    s_in_valid = 1; s_in_data = '0; s_out_ready = 1;
    tick;
    check("zero_valid", 64'(s_out_valid), 64'd1);
    check("zero_pattern", s_out_data, ZERO_PAT);
    ref_word(64, 1'b0, 64'd0, mst, exp_y, mst);

    // back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      s_in_data = pat[i];
      ref_word(64, 1'b0, pat[i], mst, exp_y, mst);
      tick;
      check($sformatf("stream%0d", i), s_out_data, exp_y);
      check($sformatf("stream%0d_valid", i), 64'(s_out_valid), 64'd1);
    end

    // backpressure: output and state frozen, in_ready low
    held = exp_y;
    s_out_ready = 0; s_in_data = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    check("bp_in_ready0", 64'(s_in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("bp_hold%0d", i), s_out_data, held);
      check($sformatf("bp_ready%0d", i), 64'(s_in_ready), 64'd0);
    end
    s_out_ready = 1;
    ref_word(64, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, mst, exp_y, mst);
    tick;
    check("bp_release", s_out_data, exp_y);

    // seed_load coincident with a transfer: word uses old state, then reload
    s_in_data = 64'h0F0F_1E1E_2D2D_3C3C; s_seed_load = 1;
    ref_word(64, 1'b0, 64'h0F0F_1E1E_2D2D_3C3C, mst, exp_y, mst);
    mst = '1;
    tick;
    check("sl_word", s_out_data, exp_y);
    s_seed_load = 0; s_in_data = '0;
    tick;
    check("sl_zero_pat", s_out_data, ZERO_PAT);
    ref_word(64, 1'b0, 64'd0, mst, exp_y, mst);

    // seed_load while idle leaves output untouched
    s_in_valid = 0; s_out_ready = 0; s_seed_load = 1;
    tick;
    check("sl_idle_valid", 64'(s_out_valid), 64'd1);
    check("sl_idle_data", s_out_data, ZERO_PAT);
    mst = '1;
    s_seed_load = 0; s_out_ready = 1;
    tick;
    check("drain_valid", 64'(s_out_valid), 64'd0);
    tick;
    check("idle_valid", 64'(s_out_valid), 64'd0);
    s_in_valid = 1; s_in_data = '0;
    tick;
    check("idle_zero_pat", s_out_data, ZERO_PAT);

    // asynchronous reset mid-stream
    s_in_data = pat[1];
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_valid", 64'(s_out_valid), 64'd0);
    check("arst_data", s_out_data, 64'd0);
    s_in_valid = 0;
    tick;
    RST_N = 1'b1;
    #1;
    check("arst_in_ready", 64'(s_in_ready), 64'd1);
    s_in_valid = 1; s_in_data = '0;
    tick;
    check("arst_zero_pat", s_out_data, ZERO_PAT);
    s_in_valid = 0;

    // 16-bit MSB-first instance
    rst_st = '1;
    for (int i = 0; i < 4; i++) begin
      dw = '0;
      for (int k = 0; k < 16; k++) dw[k] = rpat[i][15-k];
      ref_word(16, 1'b0, dw, rst_st, yw, rst_st);
      exp16 = '0;
      for (int k = 0; k < 16; k++) exp16[15-k] = yw[k];
      rv_in_valid = 1; rv_in_data = rpat[i];
      tick;
      check($sformatf("rev%0d", i), 64'(rv_out_data), 64'(exp16));
    end
    rv_in_valid = 0;

    // loopback with random gaps; wrong-seed descrambler must resync by word 1
    got = 0; got0 = 0; sent = 0; cyc = 0; ls_acc = 0;
    while ((got < int'(NL) || got0 < int'(NL)) && cyc < 20000) begin
      if (!ls_in_valid || ls_acc) begin
        if (sent < int'(NL) && $urandom_range(0, 3) != 0) begin
          ls_in_valid = 1; ls_in_data = {$urandom, $urandom};
        end else begin
          ls_in_valid = 0;
        end
      end
      ld_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      ls_acc = ls_in_valid && ls_in_ready;
      if (ls_acc) begin
        sent_q.push_back(ls_in_data);
        sent++;
      end
      if (ld_out_valid && ld_out_ready) begin
        want = (got < sent_q.size()) ? sent_q[got] : 'x;
        check($sformatf("loop%0d", got), ld_out_data, want);
        got++;
      end
      if (d0_out_valid) begin
        if (got0 >= 1) begin
          want = (got0 < sent_q.size()) ? sent_q[got0] : 'x;
          check($sformatf("sync%0d", got0), d0_out_data, want);
        end
        got0++;
      end
      tick;
      cyc++;
    end
    check("loop_count", 64'(got), 64'(NL));
    check("sync_count", 64'(got0), 64'(NL));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
